id_ex_interlock: RTL

ID_EX_INTERLOCK -- requirements
Module: id_ex_interlock

---
 rtl/id_ex_interlock.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_interlock.sv
// ID/EX pipeline register with load-use interlock: inserts one bubble behind a load
// whose result is needed next, holds on memory stalls, squashes on flush.
module id_ex_interlock #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [2:0]           id_SR1,
  input  logic [2:0]           id_SR2,
  input  logic [2:0]           id_DR,
  input  logic                 id_sr1_needed,
  input  logic                 id_sr2_needed,
  input  logic                 id_dr_needed,
  input  logic                 id_is_load,
  input  logic [15:0]          id_pc,
  input  logic [15:0]          id_sr1_data,
  input  logic [15:0]          id_sr2_data,
  input  logic [15:0]          id_ctrl,
  input  logic                 mem_stall,
  input  logic                 flush,
  output logic                 id_ex_valid,
  output logic                 id_ex_is_load,
  output logic [2:0]           id_ex_SR1,
  output logic [2:0]           id_ex_SR2,
  output logic [2:0]           id_ex_DR,
  output logic                 id_ex_sr1_needed,
  output logic                 id_ex_sr2_needed,
  output logic                 id_ex_dr_needed,
  output logic [15:0]          id_ex_pc,
  output logic [15:0]          id_ex_sr1_data,
  output logic [15:0]          id_ex_sr2_data,
  output logic [15:0]          id_ex_ctrl,
  output logic                 stall_if_id,
  output logic                 load_reg,
  output logic [CNT_WIDTH-1:0] bubble_count,
  output logic [1:0]           state
);

  // state     | meaning
  // RUN       | pipeline advancing normally
  // LU_BUBBLE | one bubble sits in ID/EX behind a load; dependent instruction held in ID
  // MEM_HOLD  | data memory busy, every stage frozen
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    MEM_HOLD  = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_hazard;
  logic                 w_sr1_match;
  logic                 w_sr2_match;
  logic                 w_stall;
  logic                 w_cnt_sat;

  logic                 r_valid;
  logic                 r_is_load;
  logic [2:0]           r_sr1;
  logic [2:0]           r_sr2;
  logic [2:0]           r_dr;
  logic                 r_sr1_needed;
  logic                 r_sr2_needed;
  logic                 r_dr_needed;
  logic [15:0]          r_pc;
  logic [15:0]          r_sr1_data;
  logic [15:0]          r_sr2_data;
  logic [15:0]          r_ctrl;
  logic [CNT_WIDTH-1:0] r_bubble_count;

  assign w_sr1_match = id_sr1_needed && (id_SR1 == r_dr);
  assign w_sr2_match = id_sr2_needed && (id_SR2 == r_dr);
  assign w_hazard    = id_valid && r_valid && r_is_load && r_dr_needed &&
                       (w_sr1_match || w_sr2_match);
  assign w_cnt_sat   = &r_bubble_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = RUN;
    w_stall      = 1'b0;
    if (flush) begin
      w_state_next = RUN;
    end else if (mem_stall) begin
      w_state_next = MEM_HOLD;
      w_stall      = 1'b1;
    end else if (w_hazard) begin
      w_state_next = LU_BUBBLE;
      w_stall      = 1'b1;
    end
    if (reset) w_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_is_load    <= 1'b0;
      r_sr1        <= 3'd0;
      r_sr2        <= 3'd0;
      r_dr         <= 3'd0;
      r_sr1_needed <= 1'b0;
      r_sr2_needed <= 1'b0;
      r_dr_needed  <= 1'b0;
      r_pc         <= 16'd0;
      r_sr1_data   <= 16'd0;
      r_sr2_data   <= 16'd0;
      r_ctrl       <= 16'd0;
    end else if (flush || (!mem_stall && w_hazard)) begin
      // squash or bubble: only the qualifiers matter, payload fields are left as-is
      r_valid      <= 1'b0;
      r_is_load    <= 1'b0;
      r_sr1_needed <= 1'b0;
      r_sr2_needed <= 1'b0;
      r_dr_needed  <= 1'b0;
    end else if (!mem_stall) begin
      r_valid      <= id_valid;
      r_is_load    <= id_is_load && id_valid;
      r_sr1        <= id_SR1;
      r_sr2        <= id_SR2;
      r_dr         <= id_DR;
      r_sr1_needed <= id_sr1_needed && id_valid;
      r_sr2_needed <= id_sr2_needed && id_valid;
      r_dr_needed  <= id_dr_needed && id_valid;
      r_pc         <= id_pc;
      r_sr1_data   <= id_sr1_data;
      r_sr2_data   <= id_sr2_data;
      r_ctrl       <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
    end else if (!flush && !mem_stall && w_hazard && !w_cnt_sat) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign id_ex_valid      = r_valid;
  assign id_ex_is_load    = r_is_load;
  assign id_ex_SR1        = r_sr1;
  assign id_ex_SR2        = r_sr2;
  assign id_ex_DR         = r_dr;
  assign id_ex_sr1_needed = r_sr1_needed;
  assign id_ex_sr2_needed = r_sr2_needed;
  assign id_ex_dr_needed  = r_dr_needed;
  assign id_ex_pc         = r_pc;
  assign id_ex_sr1_data   = r_sr1_data;
  assign id_ex_sr2_data   = r_sr2_data;
  assign id_ex_ctrl       = r_ctrl;
  assign stall_if_id      = w_stall;
  assign load_reg         = !mem_stall;
  assign bubble_count     = r_bubble_count;
  assign state            = r_state;

endmodule
